// File: rtl/csa_resolve.sv
// csa_resolve: two-stage carry-propagate resolver turning a carry-save pair into a binary sum.
// Defining CSA_RESOLVE_COUT_EN adds the out_cout port carrying the carry out of the MSB.
module csa_resolve #(
  parameter int WIDTH = 32,
  parameter int LO    = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CSA_RESOLVE_COUT_EN
  output logic             out_cout,
`endif
  output logic [WIDTH-1:0] out_sum
);

  localparam int HI = WIDTH - LO;
`ifdef CSA_RESOLVE_COUT_EN
  localparam int HW = HI + 1;
`else
  localparam int HW = HI;
`endif

  logic          s1_valid_r;
  logic [LO-1:0] s1_lo_r;
  logic          s1_cy_r;
  logic [HI-1:0] s1_hs_r;
  logic [HI-1:0] s1_hc_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_sum_r;
`ifdef CSA_RESOLVE_COUT_EN
  logic             s2_cout_r;
`endif

  logic          adv1_s;
  logic          adv2_s;
  logic          load1_s;
  logic          load2_s;
  logic [LO:0]   lo_sum_s;
  logic [HW-1:0] hi_sum_s;

  // Stage advance conditions; in_ready depends only on stage state and out_ready.
  always_comb begin
    adv2_s  = ~s2_valid_r | out_ready;
    adv1_s  = ~s1_valid_r | adv2_s;
    load1_s = adv1_s & in_valid;
    load2_s = adv2_s & s1_valid_r;
  end

  // Half-width adders: low half from the inputs, high half from stage 1 with its carry-in.
  always_comb begin
    lo_sum_s = (LO+1)'(in_s[LO-1:0]) + (LO+1)'(in_c[LO-1:0]);
    hi_sum_s = HW'(s1_hs_r) + HW'(s1_hc_r) + HW'(s1_cy_r);
  end

  // Stage 1 occupancy: refills from in_valid whenever it is allowed to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 1 data: resolved low half, its carry-out and the untouched high halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lo_r <= '0;
      s1_cy_r <= 1'b0;
      s1_hs_r <= '0;
      s1_hc_r <= '0;
    end else if (load1_s) begin
      s1_lo_r <= lo_sum_s[LO-1:0];
      s1_cy_r <= lo_sum_s[LO];
      s1_hs_r <= in_s[WIDTH-1:LO];
      s1_hc_r <= in_c[WIDTH-1:LO];
    end else begin
      s1_lo_r <= s1_lo_r;
      s1_cy_r <= s1_cy_r;
      s1_hs_r <= s1_hs_r;
      s1_hc_r <= s1_hc_r;
    end
  end

  // Stage 2 occupancy: takes whatever stage 1 holds when the consumer makes room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Stage 2 data: full result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sum_r <= '0;
    end else if (load2_s) begin
      s2_sum_r <= {hi_sum_s[HI-1:0], s1_lo_r};
    end else begin
      s2_sum_r <= s2_sum_r;
    end
  end

`ifdef CSA_RESOLVE_COUT_EN
  // Carry out of the MSB travels with the sum it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_cout_r <= 1'b0;
    end else if (load2_s) begin
      s2_cout_r <= hi_sum_s[HI];
    end else begin
      s2_cout_r <= s2_cout_r;
    end
  end

  assign out_cout = s2_cout_r;
`endif

  assign in_ready  = adv1_s;
  assign out_valid = s2_valid_r;
  assign out_sum   = s2_sum_r;

endmodule
